// File: rtl/serial_tx.sv
// serial_tx: double-buffered UART-style transmitter; start bit, DATA_BITS LSB first, STOP_BITS stop bits.
// Bit timing comes from a terminal-count divider on clk100; every bit lasts exactly TERM_COUNT clocks.
module serial_tx #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk100,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_overrun,
    output logic                 tx
);
    localparam int TERM_COUNT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = TERM_COUNT > 1 ? $clog2(TERM_COUNT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(TERM_COUNT - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d, shift_q, shift_d;
    logic                 full_q, full_d, stop_q, stop_d, tx_q, tx_d, ovr_q, ovr_d;
    logic [2:0]           bit_q, bit_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic                 tick, start;

    assign tx         = tx_q;
    assign tx_ready   = !full_q;
    assign tx_busy    = state_q != IDLE;
    assign tx_overrun = ovr_q;
    assign tick       = baud_q == '0;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        full_d  = full_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        ovr_d   = ovr_q;
        tx_done = 1'b0;
        start   = 1'b0;
        baud_d  = state_q == IDLE ? baud_q : tick ? BAUD_MAX : baud_q - 1'b1;
        if (tx_load) begin
            if (full_q) ovr_d = 1'b1;
            else begin
                hold_d = tx_data;
                full_d = 1'b1;
            end
        end
        case (state_q)
            IDLE: start = full_q;
            START: if (tick) begin
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (tick) begin
                if (bit_q == BIT_LAST) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            STOP: if (tick) begin
                if (stop_q < STOP_LAST) stop_d = stop_q + 1'b1;
                else begin
                    tx_done = 1'b1;
                    start   = full_q;
                    state_d = IDLE;
                end
            end
        endcase
        // A queued character launches on the same edge the line frees up, so frames run gapless.
        if (start) begin
            shift_d = hold_q;
            full_d  = 1'b0;
            tx_d    = 1'b0;
            baud_d  = BAUD_MAX;
            state_d = START;
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            full_q  <= 1'b0;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: frame-level reference model checked every clock against two fast instances,
// plus bit-width measurement on a default-parameter instance.
module tb_serial_tx;
    localparam int T = 10;
    localparam int TD = 100000000 / 9600;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic       reset = 1'b1, tx_load = 1'b0;
    logic [7:0] tx_data = '0;
    logic       a_ready, a_busy, a_done, a_ovr, a_tx;
    logic       b_ready, b_busy, b_done, b_ovr, b_tx;
    logic       c_reset = 1'b1, c_load = 1'b0;
    logic [7:0] c_data = '0;
    logic       c_ready, c_busy, c_done, c_ovr, c_tx;
    logic [4:0] obs [2];

    assign obs[0] = {a_ready, a_busy, a_done, a_ovr, a_tx};
    assign obs[1] = {b_ready, b_busy, b_done, b_ovr, b_tx};

    serial_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut_a (
        .clk100(clk100), .reset(reset), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(a_ready), .tx_busy(a_busy), .tx_done(a_done), .tx_overrun(a_ovr), .tx(a_tx));
    serial_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .clk100(clk100), .reset(reset), .tx_data(tx_data[6:0]), .tx_load(tx_load),
        .tx_ready(b_ready), .tx_busy(b_busy), .tx_done(b_done), .tx_overrun(b_ovr), .tx(b_tx));
    serial_tx dut_c (
        .clk100(clk100), .reset(c_reset), .tx_data(c_data), .tx_load(c_load),
        .tx_ready(c_ready), .tx_busy(c_busy), .tx_done(c_done), .tx_overrun(c_ovr), .tx(c_tx));

    int checks = 0, errors = 0;
    bit c_fin = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a one-slot queue feeding a line that is busy for a whole frame.
    int         dbits [2] = '{8, 7};
    int         sbits [2] = '{1, 2};
    bit         act [2], hv [2], ovr [2];
    int         pos [2];
    logic [7:0] cur [2], hb [2];

    function automatic int flen(input int i);
        return (1 + dbits[i] + sbits[i]) * T;
    endfunction

    function automatic logic exp_tx(input int i);
        int k;
        if (!act[i]) return 1'b1;
        k = pos[i] / T;
        if (k == 0) return 1'b0;
        if (k <= dbits[i]) return cur[i][k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input bit rst, input bit ld, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i] = 0; hv[i] = 0; ovr[i] = 0; pos[i] = 0;
            end else begin
                bit acc;
                acc = ld && !hv[i];
                if (ld && hv[i]) ovr[i] = 1;
                if (act[i]) begin
                    pos[i]++;
                    if (pos[i] == flen(i)) act[i] = 0;
                end
                if (!act[i] && hv[i]) begin
                    act[i] = 1; pos[i] = 0; cur[i] = hb[i]; hv[i] = 0;
                end
                if (acc) begin
                    hv[i] = 1; hb[i] = d;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx[%0d]", i), obs[i][0], exp_tx(i));
            check($sformatf("tx_overrun[%0d]", i), obs[i][1], ovr[i]);
            check($sformatf("tx_done[%0d]", i), obs[i][2], act[i] && pos[i] == flen(i) - 1);
            check($sformatf("tx_busy[%0d]", i), obs[i][3], act[i]);
            check($sformatf("tx_ready[%0d]", i), obs[i][4], !hv[i]);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [7:0] d);
        reset = rst; tx_load = ld; tx_data = d;
        @(posedge clk100);
        model_edge(rst, ld, d);
        #1 check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    initial begin
        int g;
        repeat (3) step(1, 0, 8'h00);
        step(0, 1, 8'h55);
        idle(110);
        step(0, 1, 8'hA5);
        while (hv[0]) step(0, 0, 8'h00);
        step(0, 1, 8'h3C);
        idle(210);
        step(0, 1, 8'h11);
        step(0, 0, 8'h00);
        step(0, 1, 8'h22);
        step(0, 1, 8'h33);
        idle(220);
        step(0, 1, 8'h77);
        idle(45);
        step(1, 0, 8'h00);
        step(0, 1, 8'h5A);
        idle(110);
        step(0, 1, 8'h7F);
        idle(110);
        repeat (1500) step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, 8'($urandom));
        g = 0;
        while (!c_fin && g < 40000) begin
            step(0, 0, 8'h00);
            g++;
        end
        check("c_timeout", c_fin, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Default parameters: 'A' = 0x41, so the line reads start 0, bit0 1, bits 1..5 0.
    initial begin
        int n;
        repeat (2) @(posedge clk100);
        #1 check("c_reset_tx", c_tx, 1);
        check("c_reset_ready", c_ready, 1);
        c_reset = 1'b0; c_load = 1'b1; c_data = 8'h41;
        @(posedge clk100);
        #1 c_load = 1'b0;
        check("c_ready_after_load", c_ready, 0);
        @(posedge clk100);
        #1 check("c_start_fall", c_tx, 0);
        n = 0;
        while (c_tx == 1'b0 && n < 20000) begin
            @(posedge clk100);
            #1 n++;
        end
        check("c_start_len", n, TD);
        n = 0;
        while (c_tx == 1'b1 && n < 20000) begin
            @(posedge clk100);
            #1 n++;
        end
        check("c_bit0_len", n, TD);
        repeat (TD / 2) @(posedge clk100);
        #1 check("c_bit1", c_tx, 0);
        repeat (TD) @(posedge clk100);
        #1 check("c_bit2", c_tx, 0);
        check("c_busy", c_busy, 1);
        check("c_ovr", c_ovr, 0);
        c_fin = 1'b1;
    end
endmodule
